// File: rtl/led_fade_pwm.sv
// LED fade stage: turns a 1-bit on/off request into a PWM LED drive.
// The brightness ramps one LSB per STEP_CYCLES clocks toward full on or full off.
module led_fade_pwm #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 98039
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_req,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - 1'b1;
  // Keep the prescaler at least one bit wide when STEP_CYCLES is 1.
  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    StOff,
    StUp,
    StOn,
    StDown
  } state_e;

  state_e              state_q;
  logic                req_meta;
  logic                req_s;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                tick;

  // Two-flop synchronizer for the (possibly asynchronous) request level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= led_req;
      req_s    <= req_meta;
    end
  end

  // Free-running PWM counter; it wraps from MAX back to 0 on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Registered LED drive; the MAX term keeps full brightness glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= (duty == MAX) | (pwm_cnt < duty);
    end
  end

  assign tick = (step_cnt == STEP_LAST);

  // Ramp FSM; it also owns duty, busy and the step prescaler.
  // A request reversal wins over a step tick in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      duty     <= '0;
      busy     <= 1'b0;
      step_cnt <= '0;
    end else begin
      case (state_q)
        StOff: begin
          duty     <= '0;
          step_cnt <= '0;
          if (req_s) begin
            state_q <= StUp;
            busy    <= 1'b1;
          end
        end
        StUp: begin
          if (!req_s) begin
            state_q  <= StDown;
            step_cnt <= '0;
          end else if (duty == MAX) begin
            state_q  <= StOn;
            busy     <= 1'b0;
            step_cnt <= '0;
          end else if (tick) begin
            duty     <= duty + 1'b1;
            step_cnt <= '0;
            // Reaching full brightness ends the ramp on the same edge.
            if (duty == MAX_M1) begin
              state_q <= StOn;
              busy    <= 1'b0;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        StOn: begin
          duty     <= MAX;
          step_cnt <= '0;
          if (!req_s) begin
            state_q <= StDown;
            busy    <= 1'b1;
          end
        end
        StDown: begin
          if (req_s) begin
            state_q  <= StUp;
            step_cnt <= '0;
          end else if (duty == '0) begin
            state_q  <= StOff;
            busy     <= 1'b0;
            step_cnt <= '0;
          end else if (tick) begin
            duty     <= duty - 1'b1;
            step_cnt <= '0;
            if (duty == {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
              state_q <= StOff;
              busy    <= 1'b0;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: begin
          state_q  <= StOff;
          duty     <= '0;
          busy     <= 1'b0;
          step_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Testbench for led_fade_pwm with PWM_BITS=3, STEP_CYCLES=4.
module tb_led_fade_pwm;

  localparam int PW   = 3;
  localparam int STEP = 4;
  localparam int MAXV = 7;

  logic          clk;
  logic          rst_n;
  logic          led_req;
  logic          led;
  logic [PW-1:0] duty;
  logic          busy;

  int errors = 0;
  int checks = 0;

  led_fade_pwm #(
    .PWM_BITS   (PW),
    .STEP_CYCLES(STEP)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .led_req(led_req),
    .led    (led),
    .duty   (duty),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: brightness chases a target (MAX if request, else 0) one step
  // per STEP cycles; a direction change restarts the step interval.
  typedef struct {
    int duty;
    int pwm;
    int cnt;
    bit s1;
    bit s2;
    bit ramp;
    bit dir;
    bit led;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, bit req);
    model_t n   = c;
    bit     r   = c.s2;
    int     tgt = r ? MAXV : 0;
    n.led = (c.duty == MAXV) || (c.pwm < c.duty);
    n.pwm = (c.pwm + 1) % (MAXV + 1);
    n.s2  = c.s1;
    n.s1  = req;
    if (!c.ramp) begin
      n.cnt = 0;
      if (c.duty != tgt) begin
        n.ramp = 1'b1;
        n.dir  = r;
      end
    end else if (c.dir != r) begin
      n.dir = r;
      n.cnt = 0;
    end else if (c.duty == tgt) begin
      n.ramp = 1'b0;
      n.cnt  = 0;
    end else if (c.cnt == STEP - 1) begin
      n.duty = c.duty + (r ? 1 : -1);
      n.cnt  = 0;
      if (n.duty == tgt) n.ramp = 1'b0;
    end else begin
      n.cnt = c.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m, led_req);
  end

  task automatic test_reset();
    rst_n   = 1'b0;
    led_req = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (led !== 1'b0 || duty !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: led=%b duty=%0d busy=%b, required 0/0/0", led, duty, busy);
      end
    end
  endtask

  task automatic test_ramp_up();
    bit exp_busy;
    // Release with led_req already high; busy rises after the third edge.
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      exp_busy = (e == 3);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL up_latency edge %0d: busy=%b, required %b", e, busy, exp_busy);
      end
    end
    repeat (28) begin
      @(negedge clk);
      checks++;
      if (duty !== PW'(m.duty) || busy !== m.ramp || led !== m.led) begin
        errors++;
        $display("FAIL ramp_up: duty=%0d busy=%b led=%b, required %0d %b %b",
                 duty, busy, led, m.duty, m.ramp, m.led);
      end
    end
    checks++;
    if (duty !== 3'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL up_done: duty=%0d busy=%b, required 7 0", duty, busy);
    end
    @(negedge clk);
    repeat (16) begin
      @(negedge clk);
      checks++;
      if (led !== 1'b1) begin
        errors++;
        $display("FAIL on_led: led=%b, required 1", led);
      end
    end
  endtask

  task automatic test_ramp_down();
    int prev = MAXV;
    led_req = 1'b0;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (duty !== PW'(m.duty) || busy !== m.ramp || led !== m.led) begin
        errors++;
        $display("FAIL ramp_down: duty=%0d busy=%b led=%b, required %0d %b %b",
                 duty, busy, led, m.duty, m.ramp, m.led);
      end
      if (int'(duty) != prev) begin
        checks++;
        if (int'(duty) != prev - 1) begin
          errors++;
          $display("FAIL down_step: duty=%0d, required %0d", duty, prev - 1);
        end
        prev = int'(duty);
      end
    end
    checks++;
    if (duty !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL down_done: duty=%0d busy=%b, required 0 0", duty, busy);
    end
  endtask

  task automatic test_reversal();
    bit found = 1'b0;
    led_req = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (duty == 3'd4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rev_reach4: duty=%0d, required 4 within 100 cycles", duty);
    end
    led_req = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (duty != 3'd4) found = 1'b1;
    end
    checks++;
    if (!found || duty !== 3'd3) begin
      errors++;
      $display("FAIL rev_next: duty=%0d, required 3", duty);
    end
    repeat (30) begin
      @(negedge clk);
      checks++;
      if (duty !== PW'(m.duty) || busy !== m.ramp || led !== m.led) begin
        errors++;
        $display("FAIL rev_tail: duty=%0d busy=%b led=%b, required %0d %b %b",
                 duty, busy, led, m.duty, m.ramp, m.led);
      end
    end
  endtask

  task automatic test_pwm_off();
    int highs = 0;
    led_req = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (led) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL off_led: led high %0d of 100 cycles, required 0", highs);
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    led_req = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (duty == 3'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL arst_reach5: duty=%0d, required 5 within 100 cycles", duty);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (duty !== 3'd0 || led !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_clear: duty=%0d led=%b busy=%b, required 0 0 0", duty, led, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Sync (2) + entry (1) + one step (4) edges until duty first moves.
    repeat (7) @(negedge clk);
    checks++;
    if (duty !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_restart: duty=%0d busy=%b, required 1 1", duty, busy);
    end
    repeat (30) begin
      @(negedge clk);
      checks++;
      if (duty !== PW'(m.duty) || busy !== m.ramp || led !== m.led) begin
        errors++;
        $display("FAIL arst_ramp: duty=%0d busy=%b led=%b, required %0d %b %b",
                 duty, busy, led, m.duty, m.ramp, m.led);
      end
    end
  endtask

  task automatic test_pulse();
    int busy_cycles = 0;
    led_req = 1'b0;
    repeat (45) @(negedge clk);
    checks++;
    if (duty !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse_idle: duty=%0d busy=%b, required 0 0", duty, busy);
    end
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      checks++;
      if (duty !== 3'd0 || busy !== m.ramp) begin
        errors++;
        $display("FAIL pulse: duty=%0d busy=%b, required 0 %b", duty, busy, m.ramp);
      end
    end
    checks++;
    if (busy_cycles < 1 || busy_cycles > 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse_busy: busy cycles=%0d final=%b, required 1..2 and final 0",
               busy_cycles, busy);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 40; s++) begin
      led_req = 1'($urandom_range(0, 1));
      hold    = $urandom_range(1, 40);
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (duty !== PW'(m.duty) || busy !== m.ramp || led !== m.led) begin
          errors++;
          $display("FAIL random seg %0d: duty=%0d busy=%b led=%b, required %0d %b %b",
                   s, duty, busy, led, m.duty, m.ramp, m.led);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    led_req = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_pwm_off();
    test_async_reset();
    test_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
